// File: rtl/store_buffer.sv
// In-order store buffer between the store datapath and DataMemory.
// Define STORE_BUFFER_FWD_EN to build in store-to-load forwarding.
module store_buffer #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [N-1:0]             st_addr,
  input  logic [N-1:0]             st_data,
  output logic                     mem_wr_en,
  output logic [N-1:0]             mem_wr_addr,
  output logic [N-1:0]             mem_wr_data,
  input  logic                     mem_ready,
  input  logic [N-1:0]             ld_addr,
  output logic                     fwd_hit,
  output logic [N-1:0]             fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  addr_q [DEPTH];
  logic [N-1:0]  data_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          full;
  logic          push;
  logic          pop;

  assign full        = (count == CW'(DEPTH));
  assign st_ready    = !full && !rst;
  assign mem_wr_en   = (count != '0) && !rst;
  assign push        = st_valid && st_ready;
  assign pop         = mem_wr_en && mem_ready;
  assign mem_wr_addr = addr_q[head];
  assign mem_wr_data = data_q[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  // Walk oldest to newest so the last match wins (newest store).
  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < count) && (addr_q[idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
    if (rst) fwd_hit = 1'b0;
  end
`else
  logic unused_ld;
  assign unused_ld = ^ld_addr;
  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: drains are checked against a
// queue of expected stores filled as the stimulus is driven.
module tb_store_buffer;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic          st_ready;
  logic [N-1:0]  st_addr;
  logic [N-1:0]  st_data;
  logic          mem_wr_en;
  logic [N-1:0]  mem_wr_addr;
  logic [N-1:0]  mem_wr_data;
  logic          mem_ready;
  logic [N-1:0]  ld_addr;
  logic          fwd_hit;
  logic [N-1:0]  fwd_data;
  logic [2:0]    count;

  int vectors = 0;
  int miscompares = 0;

  logic [2*N-1:0] sb [$];

  store_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_ready(mem_ready),
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Every accepted memory write must match the oldest expected store.
  always @(negedge clk) begin
    if (mem_wr_en && mem_ready) begin
      logic [2*N-1:0] e;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL drain_unexpected: got addr=%h data=%h, want none",
                 mem_wr_addr, mem_wr_data);
      end else begin
        e = sb.pop_front();
        if ({mem_wr_addr, mem_wr_data} !== e) begin
          miscompares++;
          $display("FAIL drain_order: got %h/%h, want %h/%h",
                   mem_wr_addr, mem_wr_data, e[2*N-1:N], e[N-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic [N-1:0] a, input logic [N-1:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    sb.push_back({a, d});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    @(negedge clk);
    vectors++;
    if (sb.size() != 0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL drain_done: pending=%0d count=%0d, want 0/0",
               sb.size(), count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    mem_ready = 1'b0; ld_addr = '0;
    step();
    @(negedge clk);
    vectors++;
    if (st_ready !== 1'b0 || mem_wr_en !== 1'b0 || fwd_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: rdy=%b wr=%b hit=%b, want 0/0/0",
               st_ready, mem_wr_en, fwd_hit);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd0 || st_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d rdy=%b wr=%b, want 0/1/0",
               count, st_ready, mem_wr_en);
    end
  endtask

  task automatic test_single();
    step();
    mem_ready = 1'b1;
    drive_st(32'h6, 32'h11);
    @(negedge clk);
    vectors++;
    if (mem_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency: wr=%b, want 0", mem_wr_en);
    end
    step();
    st_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_wr_en !== 1'b1 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL single_visible: wr=%b count=%0d, want 1/1",
               mem_wr_en, count);
    end
    step();
    @(negedge clk);
    vectors++;
    if (count !== 3'd0 || mem_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_empty: count=%0d wr=%b, want 0/0",
               count, mem_wr_en);
    end
  endtask

  task automatic test_full();
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      drive_st(32'(i * 4), 32'(32'h100 + i));
    end
    step();
    st_valid = 1'b1;
    st_addr  = 32'h10;
    st_data  = 32'hDEAD;
    @(negedge clk);
    vectors++;
    if (count !== 3'd4 || st_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state: count=%0d rdy=%b, want 4/0",
               count, st_ready);
    end
    step();
    st_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd4 || mem_wr_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL full_ignore: count=%0d head=%h, want 4/0",
               count, mem_wr_addr);
    end
    mem_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    step();
    drive_st(32'hA0, 32'h1);
    step();
    drive_st(32'hA4, 32'h2);
    step();
    st_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd2) begin
      miscompares++;
      $display("FAIL b2b_fill: count=%0d, want 2", count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      mem_ready = 1'b1;
      drive_st(32'(32'hB0 + i * 4), 32'(32'h10 + i));
      step();
      st_valid = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (count !== 3'd2) begin
        miscompares++;
        $display("FAIL b2b_count: got %0d, want 2 (iter %0d)", count, i);
      end
    end
    mem_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_forward();
    logic       eh;
    logic [N-1:0] ed;
`ifdef STORE_BUFFER_FWD_EN
    eh = 1'b1; ed = 32'hBB;
`else
    eh = 1'b0; ed = 32'h0;
`endif
    mem_ready = 1'b0;
    step();
    ld_addr = 32'h8;
    drive_st(32'h8, 32'hAA);
    @(negedge clk);
    vectors++;
    if (fwd_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_same_cycle: hit=%b, want 0", fwd_hit);
    end
    step();
    drive_st(32'h8, 32'hBB);
    step();
    st_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (fwd_hit !== eh || fwd_data !== ed) begin
      miscompares++;
      $display("FAIL fwd_newest: hit=%b data=%h, want %b/%h",
               fwd_hit, fwd_data, eh, ed);
    end
    step();
    ld_addr = 32'h10;
    @(negedge clk);
    vectors++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL fwd_miss: hit=%b data=%h, want 0/0", fwd_hit, fwd_data);
    end
    step();
    ld_addr = 32'h8;
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (fwd_hit !== eh || fwd_data !== ed) begin
      miscompares++;
      $display("FAIL fwd_popping: hit=%b data=%h, want %b/%h",
               fwd_hit, fwd_data, eh, ed);
    end
    wait_drain();
    ld_addr = '0;
  endtask

  task automatic test_reset_mid_drain();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      drive_st(32'(32'hC0 + i * 4), 32'(32'h20 + i));
    end
    step();
    st_valid = 1'b0;
    mem_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_wr_en !== 1'b0 || st_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_hold: wr=%b rdy=%b, want 0/0",
               mem_wr_en, st_ready);
    end
    step();
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd0 || mem_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: count=%0d wr=%b, want 0/0",
               count, mem_wr_en);
    end
    step();
    step();
    drive_st(32'hE0, 32'h77);
    step();
    st_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_forward();
    test_reset_mid_drain();
    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
